// File: rtl/music_pkg.sv
// Shared tune identifiers, timing defaults and priority helpers for the
// tune arbiter and the music player.
package music_pkg;

  localparam int unsigned NOTE_Pulse_Per_Sec = 50_000;

  localparam int unsigned BTN_CYC_DEF  = 50_002;
  localparam int unsigned LONG_CYC_DEF = 1_750_005;
  localparam int unsigned GAP_CYC_DEF  = 100_000;

  // Encoding doubles as priority rank: a larger value outranks a smaller one.
  typedef enum logic [1:0] {
    TUNE_None     = 2'd0,
    TUNE_BTN      = 2'd1,
    TUNE_YouWin   = 2'd2,
    TUNE_GameOver = 2'd3
  } tune_id_t;

  // Pending vector layout: bit0 btn, bit1 win, bit2 gameover.
  function automatic tune_id_t top_pending(input logic [2:0] pend);
    if (pend[2]) return TUNE_GameOver;
    if (pend[1]) return TUNE_YouWin;
    if (pend[0]) return TUNE_BTN;
    return TUNE_None;
  endfunction

  function automatic logic [2:0] tune_mask(input tune_id_t tune);
    case (tune)
      TUNE_BTN:      return 3'b001;
      TUNE_YouWin:   return 3'b010;
      TUNE_GameOver: return 3'b100;
      default:       return 3'b000;
    endcase
  endfunction

  function automatic logic outranks(input tune_id_t cand, input tune_id_t cur);
    return cand > cur;
  endfunction

endpackage

// File: rtl/tune_timer.sv
// Loadable 32-bit down-counter that saturates at zero; o_done marks the
// final cycle of a loaded interval so an interval of N lasts exactly N cycles.
module tune_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [31:0] i_value,
  input  logic        i_en,
  output logic        o_done
);

  logic [31:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_en && (r_count != 32'd0)) begin
      r_count <= r_count - 32'd1;
    end
  end

  assign o_done = (r_count <= 32'd1);

endmodule

// File: rtl/tune_arbiter.sv
// Arbitrates button / victory / game-over tune requests into one-cycle start
// pulses for the music player, with preemption and an enforced silent gap.
module tune_arbiter
  import music_pkg::*;
#(
  parameter int unsigned BTN_CYC  = BTN_CYC_DEF,
  parameter int unsigned LONG_CYC = LONG_CYC_DEF,
  parameter int unsigned GAP_CYC  = GAP_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_btn,
  input  logic       req_win,
  input  logic       req_gameover,
  input  logic       mute,
  output logic       new_tune,
  output tune_id_t   tune_id,
  output logic       busy,
  output logic       dropped,
  output logic [1:0] o_dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Protocol: requests are levels sampled every cycle (no handshake); the
  // player gets new_tune for exactly one cycle and tune_id holds until the next.
  logic [1:0]  r_state;
  logic [1:0]  w_state_nx;
  logic [2:0]  r_pend;
  logic [2:0]  w_pend_nx;
  logic [2:0]  w_req;
  logic [2:0]  w_clr;
  tune_id_t    r_tune_id;
  tune_id_t    w_tune_nx;
  tune_id_t    w_top;
  logic        r_new_tune;
  logic        r_busy;
  logic        r_dropped;
  logic        w_issue;
  logic        w_abort;
  logic        w_drop;
  logic        w_tmr_load;
  logic        w_tmr_en;
  logic        w_tmr_done;
  logic [31:0] w_tmr_val;

  assign w_req = {req_gameover, req_win, req_btn};
  assign w_top = top_pending(r_pend);

  always_comb begin
    w_state_nx = r_state;
    w_issue    = 1'b0;
    w_abort    = 1'b0;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    if (mute) begin
      w_abort    = (r_state != ST_IDLE);
      w_state_nx = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_top != TUNE_None) begin
            w_issue    = 1'b1;
            w_state_nx = ST_PLAY;
          end
        end
        ST_PLAY: begin
          // Preemption beats expiry when both land on the same cycle.
          if (outranks(w_top, r_tune_id)) begin
            w_issue = 1'b1;
          end else if (w_tmr_done) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = GAP_CYC;
            w_state_nx = ST_GAP;
          end
        end
        ST_GAP: begin
          if (w_tmr_done) begin
            w_state_nx = ST_IDLE;
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
    if (w_issue) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = (w_top == TUNE_BTN) ? BTN_CYC : LONG_CYC;
    end
  end

  // A request landing on the bit being issued re-arms it rather than coalescing.
  assign w_clr     = w_issue ? tune_mask(w_top) : 3'b000;
  assign w_pend_nx = mute ? 3'b000 : ((r_pend & ~w_clr) | w_req);
  assign w_drop    = !mute && (|(w_req & r_pend & ~w_clr));
  assign w_tmr_en  = (r_state != ST_IDLE);

  always_comb begin
    w_tune_nx = r_tune_id;
    if (w_issue) begin
      w_tune_nx = w_top;
    end else if (w_abort) begin
      w_tune_nx = TUNE_None;
    end
  end

  tune_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clear (mute),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_val),
    .i_en    (w_tmr_en),
    .o_done  (w_tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pend     <= 3'b000;
      r_new_tune <= 1'b0;
      r_tune_id  <= TUNE_None;
      r_busy     <= 1'b0;
      r_dropped  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pend     <= w_pend_nx;
      r_new_tune <= w_issue | w_abort;
      r_tune_id  <= w_tune_nx;
      r_busy     <= (w_state_nx != ST_IDLE);
      r_dropped  <= w_drop;
    end
  end

  assign new_tune    = r_new_tune;
  assign tune_id     = r_tune_id;
  assign busy        = r_busy;
  assign dropped     = r_dropped;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tune_arbiter.sv
// Directed and randomized checks of tune_arbiter against a remaining-cycles
// reference model of tune arbitration.
module tb_tune_arbiter;
  import music_pkg::*;

  localparam int BTN  = 10;
  localparam int LONG = 40;
  localparam int GAP  = 5;

  logic       clk;
  logic       rst;
  logic       req_btn;
  logic       req_win;
  logic       req_gameover;
  logic       mute;
  logic       new_tune;
  tune_id_t   tune_id;
  logic       busy;
  logic       dropped;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_mis = 0;

  // Scoreboard vector: {new_tune, tune_id[1:0], busy, dropped, state[1:0]}
  logic [6:0] exp_q[$];

  // Reference model: pending flags per tune id, cycles of playback and gap left.
  logic [3:0] m_pend;
  int         m_play_left;
  int         m_gap_left;
  tune_id_t   m_id;

  tune_arbiter #(
    .BTN_CYC  (BTN),
    .LONG_CYC (LONG),
    .GAP_CYC  (GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_btn      (req_btn),
    .req_win      (req_win),
    .req_gameover (req_gameover),
    .mute         (mute),
    .new_tune     (new_tune),
    .tune_id      (tune_id),
    .busy         (busy),
    .dropped      (dropped),
    .o_dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] obs_vec();
    return {new_tune, tune_id, busy, dropped, dbg_state};
  endfunction

  function automatic int tune_len(input tune_id_t t);
    return (t == TUNE_BTN) ? BTN : LONG;
  endfunction

  task automatic check_vec(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend      = '0;
    m_play_left = 0;
    m_gap_left  = 0;
    m_id        = TUNE_None;
    exp_q.delete();
  endtask

  task automatic model_step(input logic b, input logic w, input logic g, input logic m);
    logic       e_new;
    logic       e_drop;
    logic       e_busy;
    logic [1:0] e_st;
    logic [3:0] req;
    tune_id_t   best;
    e_new  = 1'b0;
    e_drop = 1'b0;
    req    = {g, w, b, 1'b0};
    if (m) begin
      if (m_play_left > 0 || m_gap_left > 0) begin
        e_new = 1'b1;
        m_id  = TUNE_None;
      end
      m_play_left = 0;
      m_gap_left  = 0;
      m_pend      = '0;
    end else begin
      best = TUNE_None;
      for (int t = 1; t <= 3; t++) if (m_pend[t]) best = tune_id_t'(t);
      if (best != TUNE_None &&
          ((m_play_left == 0 && m_gap_left == 0) ||
           (m_play_left > 0 && int'(best) > int'(m_id)))) begin
        e_new             = 1'b1;
        m_id              = best;
        m_play_left       = tune_len(best);
        m_gap_left        = 0;
        m_pend[int'(best)] = 1'b0;
      end else if (m_play_left > 0) begin
        m_play_left--;
        if (m_play_left == 0) m_gap_left = GAP;
      end else if (m_gap_left > 0) begin
        m_gap_left--;
      end
      for (int t = 1; t <= 3; t++) begin
        if (req[t]) begin
          if (m_pend[t]) e_drop = 1'b1;
          m_pend[t] = 1'b1;
        end
      end
    end
    e_busy = (m_play_left > 0 || m_gap_left > 0);
    e_st   = (m_play_left > 0) ? 2'd1 : ((m_gap_left > 0) ? 2'd2 : 2'd0);
    exp_q.push_back({e_new, m_id, e_busy, e_drop, e_st});
  endtask

  // Driver: one clock cycle of stimulus, checked one edge later.
  task automatic step(input logic b, input logic w, input logic g, input logic m, input string tag);
    logic [6:0] exp;
    @(negedge clk);
    req_btn      = b;
    req_win      = w;
    req_gameover = g;
    mute         = m;
    model_step(b, w, g, m);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL %s: observed empty expected queue, required one entry", tag);
    end else begin
      exp = exp_q.pop_front();
      check_vec(tag, obs_vec(), exp);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    req_btn      = 1'b0;
    req_win      = 1'b0;
    req_gameover = 1'b0;
    mute         = 1'b0;
    rst          = 1'b1;
    #1;
    check_vec(tag, obs_vec(), {1'b0, TUNE_None, 1'b0, 1'b0, 2'd0});
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic b;
    logic w;
    logic g;
    logic m;
    int   mute_left;
    req_btn      = 1'b0;
    req_win      = 1'b0;
    req_gameover = 1'b0;
    mute         = 1'b0;
    rst          = 1'b0;
    model_reset();

    #3 rst = 1'b1;
    #1 check_vec("reset_async", obs_vec(), {1'b0, TUNE_None, 1'b0, 1'b0, 2'd0});
    @(negedge clk);
    rst = 1'b0;
    idle(2, "reset_idle");

    // Single button tune: pulse two cycles after the request, 10 play + 5 gap.
    step(1'b1, 1'b0, 1'b0, 1'b0, "btn_req");
    step(1'b0, 1'b0, 1'b0, 1'b0, "btn_issue");
    check_vec("btn_issue_const", obs_vec(), {1'b1, TUNE_BTN, 1'b1, 1'b0, 2'd1});
    idle(14, "btn_play_gap");
    check_vec("btn_last_gap", obs_vec(), {1'b0, TUNE_BTN, 1'b1, 1'b0, 2'd2});
    step(1'b0, 1'b0, 1'b0, 1'b0, "btn_idle");
    check_vec("btn_idle_const", obs_vec(), {1'b0, TUNE_BTN, 1'b0, 1'b0, 2'd0});
    idle(3, "btn_rest");

    // Simultaneous btn + win: win first, btn after the win and its gap.
    step(1'b1, 1'b1, 1'b0, 1'b0, "dual_req");
    step(1'b0, 1'b0, 1'b0, 1'b0, "dual_issue");
    check_vec("dual_win_first", obs_vec(), {1'b1, TUNE_YouWin, 1'b1, 1'b0, 2'd1});
    idle(46, "dual_win_play");
    check_vec("dual_btn_second", obs_vec(), {1'b1, TUNE_BTN, 1'b1, 1'b0, 2'd1});
    idle(20, "dual_btn_play");

    // Game over 8 cycles into a button tune preempts it.
    step(1'b1, 1'b0, 1'b0, 1'b0, "pre_btn");
    idle(9, "pre_btn_play");
    step(1'b0, 1'b0, 1'b1, 1'b0, "pre_go_req");
    step(1'b0, 1'b0, 1'b0, 1'b0, "pre_go_issue");
    check_vec("pre_go_const", obs_vec(), {1'b1, TUNE_GameOver, 1'b1, 1'b0, 2'd1});
    idle(55, "pre_go_play");

    // Repeated wins: no self-preemption, replay once, coalesce a third.
    step(1'b0, 1'b1, 1'b0, 1'b0, "win1");
    idle(5, "win1_play");
    step(1'b0, 1'b1, 1'b0, 1'b0, "win2_silent");
    idle(3, "win2_wait");
    step(1'b0, 1'b1, 1'b0, 1'b0, "win3_req");
    check_vec("win3_dropped", obs_vec(), {1'b0, TUNE_YouWin, 1'b1, 1'b1, 2'd1});
    idle(100, "win_replay");

    // Request on the cycle its bit is issued re-arms it.
    step(1'b1, 1'b0, 1'b0, 1'b0, "setwin_a");
    step(1'b1, 1'b0, 1'b0, 1'b0, "setwin_b");
    check_vec("setwin_no_drop", obs_vec(), {1'b1, TUNE_BTN, 1'b1, 1'b0, 2'd1});
    idle(35, "setwin_replay");

    // Mute during playback.
    step(1'b0, 1'b0, 1'b1, 1'b0, "mute_go");
    idle(6, "mute_go_play");
    step(1'b1, 1'b0, 1'b0, 1'b1, "mute_hit");
    check_vec("mute_none_pulse", obs_vec(), {1'b1, TUNE_None, 1'b0, 1'b0, 2'd0});
    step(1'b1, 1'b1, 1'b1, 1'b1, "mute_reqs");
    check_vec("mute_silent", obs_vec(), {1'b0, TUNE_None, 1'b0, 1'b0, 2'd0});
    idle(5, "mute_after");

    // Reset while in the gap.
    step(1'b1, 1'b0, 1'b0, 1'b0, "rstgap_btn");
    idle(12, "rstgap_play");
    do_reset("rst_in_gap");
    idle(20, "rst_after");

    // Randomized traffic, sparse then dense.
    mute_left = 0;
    for (int i = 0; i < 3000; i++) begin
      int div;
      div = (i < 2000) ? 25 : 3;
      b = ($urandom_range(0, div) == 0);
      w = ($urandom_range(0, div * 3) == 0);
      g = ($urandom_range(0, div * 5) == 0);
      m = 1'b0;
      if (mute_left > 0) begin
        m = 1'b1;
        mute_left--;
      end else if ($urandom_range(0, 249) == 0) begin
        mute_left = $urandom_range(1, 4);
      end
      if ($urandom_range(0, 999) == 0) begin
        do_reset("rand_reset");
      end else begin
        step(b, w, g, m, "rand");
      end
    end
    idle(60, "drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/tune_arbiter.md
TUNE_ARBITER -- requirements
Module: tune_arbiter

Interface
REQ-001 SHALL have parameter BTN_CYC, default 50_002, meaning playback cycles reserved for TUNE_BTN.
REQ-002 SHALL have parameter LONG_CYC, default 1_750_005, meaning playback cycles reserved for TUNE_YouWin and TUNE_GameOver.
REQ-003 SHALL have parameter GAP_CYC, default 100_000, meaning silent cycles enforced between consecutive tunes.
REQ-004 SHALL have port clk  input  1  single system clock, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_btn  input  1  button-click tune request, level sampled each cycle.
REQ-007 SHALL have port req_win  input  1  victory tune request.
REQ-008 SHALL have port req_gameover  input  1  game-over tune request.
REQ-009 SHALL have port mute  input  1  silence and discard all requests while high.
REQ-010 SHALL have port new_tune  output  1  one-cycle start pulse to the music player.
REQ-011 SHALL have port tune_id  output  TUNE_ID  tune selected, valid while new_tune high and held afterwards.
REQ-012 SHALL have port busy  output  1  high in PLAY and GAP states.
REQ-013 SHALL have port dropped  output  1  one-cycle pulse when a request coalesces into an already-pending one.

Function
REQ-014 SHALL latch each request high in cycle N into its pending bit, visible from cycle N+1.
REQ-015 SHALL rank priority gameover > win > btn, both for IDLE selection and preemption.
REQ-016 SHALL implement FSM states IDLE, PLAY, GAP; all outputs registered.
REQ-017 IDLE with any pending bit: SHALL pulse new_tune, drive tune_id of the highest pending, clear that bit, load timer (BTN_CYC or LONG_CYC), enter PLAY; request in cycle N gives new_tune in cycle N+2.
REQ-018 PLAY: timer SHALL decrement by 1 per cycle; at timer==0 SHALL load GAP_CYC and enter GAP.
REQ-019 PLAY with a pending request of strictly higher priority than the current tune: SHALL preempt exactly as REQ-017 while staying in PLAY; the preempted tune is not re-queued.
REQ-020 Equal or lower priority pending requests SHALL wait for IDLE.
REQ-021 GAP: SHALL decrement; at 0 enter IDLE; no issue or preemption during GAP.
REQ-022 Request arriving while its pending bit is already set SHALL assert dropped for one cycle; pending stays set (coalesced, played once).
REQ-023 Request arriving in the same cycle its bit is cleared by issue SHALL leave the bit set (set wins).
REQ-024 Simultaneous requests SHALL all be latched; served in priority order.
REQ-025 mute high: SHALL clear all pending bits, ignore requests (no dropped); if in PLAY or GAP, pulse new_tune with tune_id=TUNE_None and enter IDLE next cycle.
REQ-026 Timer SHALL be 32-bit unsigned, never wrap below 0.
REQ-027 busy SHALL deassert in the first IDLE cycle.

Reset
REQ-028 On rst: state IDLE, pending 0, timer 0, new_tune 0, tune_id TUNE_None, busy 0, dropped 0, immediately and asynchronously.
REQ-029 rst mid-PLAY SHALL abandon playback with no further new_tune pulse; first pulse after release follows a new request.

Structure
REQ-030 TUNE_ID enum, NOTE_Pulse_Per_Sec and default cycle lengths SHALL live in shared package music_pkg, also used by MUSIC_PLAYER.
REQ-031 One sub-module natural: tune_timer (loadable 32-bit down-counter with zero flag).

Verification (BTN_CYC=10, LONG_CYC=40, GAP_CYC=5)
REQ-032 req_btn pulse cycle 0 -> new_tune cycle 2 with TUNE_BTN, busy for 10+5 cycles, IDLE after.
REQ-033 req_btn and req_win same cycle -> TUNE_YouWin issued first, TUNE_BTN issued after 40+5 cycles.
REQ-034 req_gameover 8 cycles into TUNE_BTN -> new_tune with TUNE_GameOver 2 cycles later, timer reloaded 40, no BTN replay.
REQ-035 Second req_win during YouWin playback -> no preemption; dropped silent; YouWin replayed once after gap; third req_win while pending -> dropped pulse.
REQ-036 mute mid-PLAY -> new_tune with TUNE_None next cycle, busy low, pending cleared; requests under mute produce nothing.
REQ-037 rst asserted mid-GAP -> all outputs zero/TUNE_None same cycle, no pulse after release.
